clkgate_ctrl: RTL

Automatic clock-gate controller for one gateable clock domain. It runs on the free-running parent clock and drives the enable input of the domain's low-holding clock-gate cell. It shuts the domain clock off after a programmable run of idle cycles. Initiators needing the domain use a level req/ack wake handshake, and the ack is only returned once the gated clock is running and settled.

---
 rtl/clkgate_ctrl_pkg.sv | 13 +
 rtl/clkgate_ctrl_stats.sv | 13 +
 rtl/clkgate_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/clkgate_ctrl_pkg.sv
// clkgate_ctrl_pkg: state encodings and helpers shared by the clock-gate controller and debug decoders.
package clkgate_ctrl_pkg;
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      IDLE = 2'd1,
      OFF  = 2'd2,
      WAKE = 2'd3
   } state_t;

   function automatic int max_int(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/clkgate_ctrl_stats.sv
// clkgate_ctrl_stats: saturating event counter, cleared only by reset.
module clkgate_ctrl_stats #(
   parameter int W_STATS = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   output logic [W_STATS-1:0] count
);
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: auto clock-gate controller with idle hysteresis and req/ack wake handshake.
// Define CLKGATE_CTRL_STATS_EN to build the saturating gated-cycle counter.
module clkgate_ctrl
   import clkgate_ctrl_pkg::*;
#(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int W_STATS     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_auto,
   input  logic               busy,
   input  logic               wake_req,
   output logic               wake_ack,
   output logic               clk_en,
   output logic               gated,
   output logic [W_STATS-1:0] gated_cycles
);
   localparam int CW = $clog2(max_int(IDLE_CYCLES, WAKE_CYCLES) + 1);

   state_t          state, next_state;
   logic [CW-1:0]   cnt, cnt_next;

   // Aborts in IDLE are checked before expiry so a late busy/req always wins.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         RUN:
            if (en_auto && !busy && !wake_req) begin
               next_state = IDLE;
               cnt_next   = CW'(IDLE_CYCLES - 1);
            end
         IDLE:
            if (busy || wake_req || !en_auto) next_state = RUN;
            else if (cnt == '0) next_state = OFF;
            else cnt_next = cnt - 1'b1;
         OFF:
            if (wake_req || !en_auto) begin
               next_state = WAKE;
               cnt_next   = CW'(WAKE_CYCLES - 1);
            end
         WAKE:
            if (cnt == '0) next_state = RUN;
            else cnt_next = cnt - 1'b1;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state    <= RUN;
         cnt      <= '0;
         clk_en   <= 1'b1;
         gated    <= 1'b0;
         wake_ack <= 1'b0;
      end else begin
         state    <= next_state;
         cnt      <= cnt_next;
         clk_en   <= next_state != OFF;
         gated    <= next_state == OFF;
         wake_ack <= wake_req && next_state == RUN;
      end

`ifdef CLKGATE_CTRL_STATS_EN
   clkgate_ctrl_stats #(.W_STATS(W_STATS)) u_stats (
      .clk   (clk),
      .rst   (rst),
      .inc   (state == OFF),
      .count (gated_cycles)
   );
`else
   assign gated_cycles = '0;
`endif
endmodule
